wishbone_interconnect_nport: RTL and testbench
==============================================

# wishbone_interconnect_nport

Parametrised N-slave Wishbone classic interconnect between one bus master and `NUM_SLAVES` slaves, decoded on the top 8 address bits. It is the registered successor of the fixed two-port interconnect. Each transaction runs through a small FSM that adds:

- per-transaction bus-timeout error termination,
- an error response for unmapped addresses,
- master-abort handling,
- a latched, maskable interrupt status/mask register pair at a reserved select code.

## Interface
Parameters:
- `NUM_SLAVES`, 4: number of slave ports, 1..32.
- `IRQ_SEL`, 8'hFF: select code of the interrupt register window.
- `TIMEOUT_CYCLES`, 256: maximum cycles slave `stb` is held without `ack`, 2..65535.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `i_m_we, i_m_stb, i_m_cyc`  in  1 each  master controls.
- `i_m_sel`  in  4  byte selects.
- `i_m_adr`  in  32  address; [31:24] = slave select.
- `i_m_dat`  in  32  write data.
- `o_m_dat`  out  32  read data (registered).
- `o_m_ack`  out  1  normal termination, one-cycle pulse.
- `o_m_err`  out  1  error termination, one-cycle pulse.
- `o_m_int`  out  1  OR of masked interrupt status.
- `o_s_we, o_s_stb, o_s_cyc`  out  NUM_SLAVES  per-slave controls.
- `o_s_sel`  out  4*NUM_SLAVES  per-slave byte selects.
- `o_s_adr, o_s_dat`  out  32*NUM_SLAVES  per-slave address/data; slave k uses slice [32k+31:32k].
- `i_s_dat`  in  32*NUM_SLAVES  per-slave read data.
- `i_s_ack, i_s_int`  in  NUM_SLAVES  per-slave ack / interrupt.

## Operation
- **FSM states:** IDLE, BUSY, ACK, ERR.
- **IDLE:**
  - On `i_m_cyc & i_m_stb`, register `we`, `sel`, `dat`, select code `idx`, and `{8'h00, adr[23:0]}`.
  - Go to BUSY if `idx < NUM_SLAVES`.
  - Go to ACK if `idx == IRQ_SEL` (register access).
  - Otherwise go to ERR.
- **BUSY:**
  - Slave `idx` gets the registered `we/sel/adr/dat` with `stb=cyc=1`. All other slave outputs are 0.
  - On `i_s_ack[idx]`: capture `i_s_dat` slice into `o_m_dat`, go to ACK.
  - Timeout counter is cleared on BUSY entry and increments each BUSY cycle without ack. At `TIMEOUT_CYCLES-1` with no ack, go to ERR. If ack arrives in that same cycle, ack wins.
  - If `i_m_cyc` falls in BUSY (master abort), drop the slave `stb/cyc` next cycle, return to IDLE, and issue no ack or err.
- **ACK:** `o_m_ack=1` for exactly one cycle, then IDLE.
- **ERR:** `o_m_err=1` and `o_m_dat=0` for one cycle, then IDLE. Slave outputs are all 0.
- **IRQ window** (`idx == IRQ_SEL`):
  - Offset 0x0, STATUS, read-only: `[NUM_SLAVES-1:0]` = registered `i_s_int`. Upper bits read 0.
  - Offset 0x4, MASK, read/write: resets to all ones, writes honour `i_m_sel`.
  - Other offsets read 0 and ignore writes; they still ack.
- `o_m_int = |(STATUS & MASK)`, registered.
- `i_m_stb` may stay high during ACK/ERR. It is only sampled in IDLE, so the master must drop `stb` the cycle after ack/err.

## Timing
- **Reset:**
  - Async assert: FSM → IDLE; all outputs 0; STATUS 0; MASK 32'hFFFF_FFFF; timeout counter 0.
  - Reset mid-transaction aborts it with no ack/err.
  - Deassertion is synchronous to `clk`.
- **Slave access:**
  - Master `stb` sampled at edge 0.
  - Slave `stb` high from cycle 1.
  - A zero-wait slave acks in cycle 1; `o_m_ack` is high in cycle 2 and slave `stb` is low in cycle 2.
  - Latency = 2 + slave wait states.
- **IRQ-window access and unmapped select:** `o_m_ack` (IRQ window) or `o_m_err` (unmapped) is high in cycle 1.
- **Timeout:** slave `stb` is held exactly `TIMEOUT_CYCLES` cycles, and `o_m_err` is high the cycle after.
- **Interrupt path:** `i_s_int` → STATUS takes 1 cycle; STATUS → `o_m_int` takes 1 cycle; total 2 cycles.
- **Ack hygiene:** an ack from a non-selected slave, or any ack outside BUSY, is ignored.

## Structure
- Package `wb_ic_pkg` holds:
  - state enum,
  - `IRQ_STATUS_OFF = 8'h0` and `IRQ_MASK_OFF = 8'h4`,
  - select field position `[31:24]`,
  - local width constants.
- One sub-module, `wb_ic_irq_regs`, holds the STATUS capture, MASK register with byte-lane write, read mux, and `o_m_int` generation.
- The top level holds the FSM, timeout counter, request registers and slave fan-out/fan-in.

## Test plan
- Write `32'hDEADBEEF` to `adr 32'h0200_0010`, slave 2 acks in cycle 1 → slave 2 sees `adr 32'h0000_0010`, `dat DEADBEEF`, `sel F`; slaves 0/1/3 all-zero; `o_m_ack` high in cycle 2 only.
- Read `adr 32'h0100_0000`, slave 1 returns `32'h12345678` after 3 wait states → `o_m_dat = 12345678` with `o_m_ack` in cycle 5.
- Read `adr 32'h0700_0000` (unmapped, `NUM_SLAVES=4`) → `o_m_err` in cycle 1, `o_m_dat = 0`, no slave `stb`.
- Slave 0 never acks, `TIMEOUT_CYCLES=16` → slave `stb` high 16 cycles, `o_m_err` on cycle 17. A second run acks on the 16th cycle → `o_m_ack`, no err.
- Assert `i_s_int = 4'b0101` → STATUS reads `32'h5` and `o_m_int=1` two cycles later. Write MASK = `32'h4` with `sel 4'b0001` → `o_m_int` stays 1. Write MASK = 0 → `o_m_int=0`.
- Drop `i_m_cyc` mid-BUSY, then assert async `rst` during a later BUSY → no ack/err either time, slave `stb` returns to 0, MASK back to all ones after reset.

Source files
------------

// File: rtl/wb_ic_pkg.sv
// Shared types and constants for the N-port Wishbone interconnect.
package wb_ic_pkg;

   localparam int unsigned DW      = 32;
   localparam int unsigned SELW    = 4;
   localparam int unsigned IDXW    = 8;
   localparam int unsigned OFFW    = 24;
   localparam int unsigned TO_W    = 16;
   localparam int unsigned SEL_MSB = 31;
   localparam int unsigned SEL_LSB = 24;

   localparam logic [7:0] IRQ_STATUS_OFF = 8'h0;
   localparam logic [7:0] IRQ_MASK_OFF   = 8'h4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_ACK,
      ST_ERR
   } state_e;

   // Master request latched at the start of a transaction.
   typedef struct packed {
      logic            we;
      logic [SELW-1:0] sel;
      logic [DW-1:0]   adr;
      logic [DW-1:0]   dat;
   } req_t;

endpackage

// File: rtl/wishbone_interconnect_nport_if.sv
// Bundle of master-side and per-slave Wishbone signals.
interface wishbone_interconnect_nport_if #(
   parameter int unsigned NUM_SLAVES = 4
);
   logic                    i_m_we;
   logic                    i_m_stb;
   logic                    i_m_cyc;
   logic [3:0]              i_m_sel;
   logic [31:0]             i_m_adr;
   logic [31:0]             i_m_dat;
   logic [31:0]             o_m_dat;
   logic                    o_m_ack;
   logic                    o_m_err;
   logic                    o_m_int;
   logic [NUM_SLAVES-1:0]   o_s_we;
   logic [NUM_SLAVES-1:0]   o_s_stb;
   logic [NUM_SLAVES-1:0]   o_s_cyc;
   logic [4*NUM_SLAVES-1:0] o_s_sel;
   logic [32*NUM_SLAVES-1:0] o_s_adr;
   logic [32*NUM_SLAVES-1:0] o_s_dat;
   logic [32*NUM_SLAVES-1:0] i_s_dat;
   logic [NUM_SLAVES-1:0]   i_s_ack;
   logic [NUM_SLAVES-1:0]   i_s_int;

   // Interconnect side.
   modport slave (
      input  i_m_we, i_m_stb, i_m_cyc, i_m_sel, i_m_adr, i_m_dat,
      input  i_s_dat, i_s_ack, i_s_int,
      output o_m_dat, o_m_ack, o_m_err, o_m_int,
      output o_s_we, o_s_stb, o_s_cyc, o_s_sel, o_s_adr, o_s_dat
   );

   // Bus master / slave-model side.
   modport master (
      output i_m_we, i_m_stb, i_m_cyc, i_m_sel, i_m_adr, i_m_dat,
      output i_s_dat, i_s_ack, i_s_int,
      input  o_m_dat, o_m_ack, o_m_err, o_m_int,
      input  o_s_we, o_s_stb, o_s_cyc, o_s_sel, o_s_adr, o_s_dat
   );
endinterface

// File: rtl/wb_ic_irq_regs.sv
// Interrupt STATUS capture, byte-writable MASK and masked interrupt output.
module wb_ic_irq_regs
   import wb_ic_pkg::*;
#(
   parameter int unsigned NUM_SLAVES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_SLAVES-1:0] s_int_i,
   input  logic                  wr_en_i,
   input  logic [SELW-1:0]       wr_sel_i,
   input  logic [DW-1:0]         wr_dat_i,
   input  logic [OFFW-1:0]       offset_i,
   output logic [DW-1:0]         rd_dat_c_o,
   output logic                  int_o
);

   localparam logic [OFFW-1:0] STATUS_OFF = OFFW'(IRQ_STATUS_OFF);
   localparam logic [OFFW-1:0] MASK_OFF   = OFFW'(IRQ_MASK_OFF);

   logic [NUM_SLAVES-1:0] status_q;
   logic [DW-1:0]         mask_q, mask_d;
   logic                  int_q, int_d;
   logic [DW-1:0]         status_c;
   logic                  mask_wr_c;

   assign status_c  = DW'(status_q);
   assign mask_wr_c = wr_en_i && (offset_i == MASK_OFF);
   assign int_d     = |(status_c & mask_q);
   assign int_o     = int_q;

   // Byte-lane MASK update.
   for (genvar b = 0; b < int'(SELW); b++) begin : g_lane
      assign mask_d[8*b +: 8] = (mask_wr_c && wr_sel_i[b]) ? wr_dat_i[8*b +: 8]
                                                           : mask_q[8*b +: 8];
   end

   // Register window read mux on the live offset.
   always_comb begin
      rd_dat_c_o = '0;
      if (offset_i == STATUS_OFF) rd_dat_c_o = status_c;
      else if (offset_i == MASK_OFF) rd_dat_c_o = mask_q;
   end

   // STATUS sampling, MASK storage and registered interrupt.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         status_q <= '0;
         mask_q   <= '1;
         int_q    <= 1'b0;
      end else begin
         status_q <= s_int_i;
         mask_q   <= mask_d;
         int_q    <= int_d;
      end
   end

endmodule

// File: rtl/wishbone_interconnect_nport.sv
// Registered N-slave Wishbone classic interconnect with timeout, unmapped
// error, master abort and an interrupt register window.
module wishbone_interconnect_nport
   import wb_ic_pkg::*;
#(
   parameter int unsigned NUM_SLAVES     = 4,
   parameter logic [7:0]  IRQ_SEL        = 8'hFF,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input logic                        clk,
   input logic                        rst,
   wishbone_interconnect_nport_if.slave bus
);

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   state_e                state_q, state_d;
   req_t                  req_q, req_d;
   logic [TO_W-1:0]       cnt_q, cnt_d;
   logic [NUM_SLAVES-1:0] oh_q, oh_d;
   logic [DW-1:0]         dat_q, dat_d;
   logic                  ack_q, ack_d;
   logic                  err_q, err_d;

   logic [IDXW-1:0]       idx_c;
   logic [NUM_SLAVES-1:0] sel_oh_c;
   logic                  start_c, hit_c, irq_wr_c;
   logic [DW-1:0]         s_rd_c, irq_rd_c;
   logic [DW-1:0]         rd_chain [NUM_SLAVES+1];

   assign idx_c    = bus.i_m_adr[SEL_MSB:SEL_LSB];
   assign start_c  = (state_q == ST_IDLE) && bus.i_m_cyc && bus.i_m_stb;
   assign hit_c    = |(bus.i_s_ack & oh_q);
   assign irq_wr_c = start_c && (idx_c == IRQ_SEL) && bus.i_m_we;
   assign rd_chain[0] = '0;
   assign s_rd_c   = rd_chain[NUM_SLAVES];

   // Per-slave decode, request fan-out and read-data fan-in.
   for (genvar k = 0; k < int'(NUM_SLAVES); k++) begin : g_slv
      assign sel_oh_c[k]              = (idx_c == IDXW'(k));
      assign bus.o_s_stb[k]           = oh_q[k];
      assign bus.o_s_cyc[k]           = oh_q[k];
      assign bus.o_s_we[k]            = oh_q[k] & req_q.we;
      assign bus.o_s_sel[SELW*k +: SELW] = oh_q[k] ? req_q.sel : '0;
      assign bus.o_s_adr[DW*k +: DW]  = oh_q[k] ? req_q.adr : '0;
      assign bus.o_s_dat[DW*k +: DW]  = oh_q[k] ? req_q.dat : '0;
      assign rd_chain[k+1] = rd_chain[k] | ({DW{oh_q[k]}} & bus.i_s_dat[DW*k +: DW]);
   end

   assign bus.o_m_dat = dat_q;
   assign bus.o_m_ack = ack_q;
   assign bus.o_m_err = err_q;

   wb_ic_irq_regs #(
      .NUM_SLAVES (NUM_SLAVES)
   ) u_irq (
      .clk        (clk),
      .rst        (rst),
      .s_int_i    (bus.i_s_int),
      .wr_en_i    (irq_wr_c),
      .wr_sel_i   (bus.i_m_sel),
      .wr_dat_i   (bus.i_m_dat),
      .offset_i   (bus.i_m_adr[OFFW-1:0]),
      .rd_dat_c_o (irq_rd_c),
      .int_o      (bus.o_m_int)
   );

   // Transaction FSM: decode, slave wait/timeout/abort, one-cycle responses.
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      cnt_d   = '0;
      oh_d    = '0;
      dat_d   = dat_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start_c) begin
               req_d.we  = bus.i_m_we;
               req_d.sel = bus.i_m_sel;
               req_d.adr = {8'h00, bus.i_m_adr[OFFW-1:0]};
               req_d.dat = bus.i_m_dat;
               if (32'(idx_c) < NUM_SLAVES) begin
                  state_d = ST_BUSY;
                  oh_d    = sel_oh_c;
               end else if (idx_c == IRQ_SEL) begin
                  state_d = ST_ACK;
                  ack_d   = 1'b1;
                  dat_d   = irq_rd_c;
               end else begin
                  state_d = ST_ERR;
                  err_d   = 1'b1;
                  dat_d   = '0;
               end
            end
         end
         ST_BUSY: begin
            if (!bus.i_m_cyc) begin
               state_d = ST_IDLE;
            end else if (hit_c) begin
               state_d = ST_ACK;
               ack_d   = 1'b1;
               dat_d   = s_rd_c;
            end else if (cnt_q == TO_LAST) begin
               state_d = ST_ERR;
               err_d   = 1'b1;
               dat_d   = '0;
            end else begin
               oh_d  = oh_q;
               cnt_d = cnt_q + TO_W'(1);
            end
         end
         ST_ACK:  state_d = ST_IDLE;
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State, request and response registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         req_q   <= '0;
         cnt_q   <= '0;
         oh_q    <= '0;
         dat_q   <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         cnt_q   <= cnt_d;
         oh_q    <= oh_d;
         dat_q   <= dat_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_wishbone_interconnect_nport.sv
// Randomised self-checking bench for wishbone_interconnect_nport.
module tb_wishbone_interconnect_nport;

   localparam int NS = 4;
   localparam int T  = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wishbone_interconnect_nport_if #(.NUM_SLAVES(NS)) bus ();

   wishbone_interconnect_nport #(
      .NUM_SLAVES     (NS),
      .IRQ_SEL        (8'hFF),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state of the interrupt window.
   logic [31:0]   mask_m;
   logic [NS-1:0] int_m;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic exp_int();
      return |(int_m & mask_m[NS-1:0]);
   endfunction

   task automatic master_idle();
      bus.i_m_cyc = 1'b0;
      bus.i_m_stb = 1'b0;
      bus.i_m_we  = 1'b0;
   endtask

   // One master transaction with the slaves modelled by the bench.
   // waits < 0: target never acks. abort_cyc/rst_cyc > 0: drop cyc / pulse rst in that cycle.
   task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input int waits, input logic [31:0] sdat,
                          input int abort_cyc, input int rst_cyc);
      logic [7:0]  idx;
      logic [23:0] off;
      int          tgt;
      logic        e_ack, e_err, chk_dat;
      int          e_cyc, e_stb;
      logic [31:0] e_dat;
      logic        g_ack, g_err, bad;
      int          g_cyc, stb_cnt, c;
      logic [31:0] g_dat, sn_adr, sn_dat;
      logic [3:0]  sn_sel;
      logic        sn_we, done;
      logic [NS-1:0] tmask;

      idx = adr[31:24]; off = adr[23:0];
      tgt = -1; e_ack = 0; e_err = 0; e_cyc = 0; e_stb = 0; e_dat = '0; chk_dat = 1;
      if (abort_cyc > 0 || rst_cyc > 0) begin
         tgt = int'(idx); e_stb = (abort_cyc > 0) ? abort_cyc : rst_cyc; chk_dat = 0;
      end else if (int'(idx) < NS) begin
         tgt = int'(idx);
         if (waits >= 0 && waits < T) begin
            e_ack = 1; e_cyc = waits + 2; e_stb = waits + 1; e_dat = sdat;
         end else begin
            e_err = 1; e_cyc = T + 1; e_stb = T;
         end
      end else if (idx == 8'hFF) begin
         e_ack = 1; e_cyc = 1; chk_dat = !we;
         e_dat = (off == 24'h0) ? 32'(int_m) : (off == 24'h4) ? mask_m : 32'h0;
      end else begin
         e_err = 1; e_cyc = 1;
      end
      tmask = (tgt >= 0) ? NS'(1) << tgt : '0;

      bus.i_m_we = we; bus.i_m_adr = adr; bus.i_m_dat = dat; bus.i_m_sel = sel;
      bus.i_m_cyc = 1'b1; bus.i_m_stb = 1'b1;
      g_ack = 0; g_err = 0; g_cyc = 0; g_dat = '0; bad = 0; stb_cnt = 0; c = 0; done = 0;
      sn_adr = '0; sn_dat = '0; sn_sel = '0; sn_we = 0;
      while (!done) begin
         @(negedge clk);
         c++;
         if (rst_cyc > 0 && c == rst_cyc + 1) rst = 1'b0;
         for (int k = 0; k < NS; k++) begin
            if (bus.o_s_stb[k] || bus.o_s_cyc[k]) begin
               if (k == tgt && bus.o_s_stb[k] && bus.o_s_cyc[k]) begin
                  stb_cnt++;
                  if (stb_cnt == 1) begin
                     sn_adr = bus.o_s_adr[32*k +: 32]; sn_dat = bus.o_s_dat[32*k +: 32];
                     sn_sel = bus.o_s_sel[4*k +: 4];   sn_we  = bus.o_s_we[k];
                  end
               end else bad = 1;
            end
            if ((k != tgt || !bus.o_s_stb[k]) &&
                (bus.o_s_we[k] || bus.o_s_sel[4*k +: 4] != 4'h0 ||
                 bus.o_s_adr[32*k +: 32] != 32'h0 || bus.o_s_dat[32*k +: 32] != 32'h0))
               bad = 1;
         end
         if (bus.o_m_ack || bus.o_m_err) begin
            if (g_cyc == 0) begin
               g_ack = bus.o_m_ack; g_err = bus.o_m_err; g_cyc = c; g_dat = bus.o_m_dat;
            end else bad = 1;
            master_idle();
            done = 1;
         end
         // Slave models: stray acks from non-targets, target acks after its wait states.
         bus.i_s_ack = NS'($urandom) & ~tmask;
         bus.i_s_dat = {$urandom, $urandom, $urandom, $urandom};
         if (!done && tgt >= 0 && waits >= 0 && bus.o_s_stb[tgt] && stb_cnt == waits + 1) begin
            bus.i_s_ack[tgt] = 1'b1;
            bus.i_s_dat[32*tgt +: 32] = sdat;
         end
         if (abort_cyc > 0 && c == abort_cyc) master_idle();
         if (rst_cyc > 0 && c == rst_cyc) begin
            master_idle();
            #2 rst = 1'b1;
            #1;
            chk("rst_s_stb", 32'(bus.o_s_stb | bus.o_s_cyc), 32'h0);
            chk("rst_m_out", {29'h0, bus.o_m_ack, bus.o_m_err, bus.o_m_int}, 32'h0);
            chk("rst_m_dat", bus.o_m_dat, 32'h0);
         end
         if ((abort_cyc > 0 && c >= abort_cyc + 3) || (rst_cyc > 0 && c >= rst_cyc + 3) ||
             c >= T + 40)
            done = 1;
      end
      bus.i_s_ack = '0;
      master_idle();
      if (c >= T + 40) chk("txn_budget", 32'(c), 32'(T + 40 - 1));

      chk("m_ack", 32'(g_ack), 32'(e_ack));
      chk("m_err", 32'(g_err), 32'(e_err));
      if (e_ack || e_err) chk("latency", 32'(g_cyc), 32'(e_cyc));
      if (chk_dat && (e_ack || e_err)) chk("m_dat", g_dat, e_dat);
      chk("stb_cycles", 32'(stb_cnt), 32'(e_stb));
      chk("slv_clean", 32'(bad), 32'h0);
      if (tgt >= 0 && e_stb > 0) begin
         chk("s_adr", sn_adr, {8'h00, adr[23:0]});
         chk("s_dat", sn_dat, dat);
         chk("s_sel", 32'(sn_sel), 32'(sel));
         chk("s_we",  32'(sn_we), 32'(we));
      end

      if (rst_cyc > 0) mask_m = '1;
      else if (idx == 8'hFF && we && off == 24'h4)
         for (int b = 0; b < 4; b++) if (sel[b]) mask_m[8*b +: 8] = dat[8*b +: 8];
      @(negedge clk);
   endtask

   // Change slave interrupts and check the two-cycle propagation to o_m_int.
   task automatic set_int(input logic [NS-1:0] v);
      logic prev;
      prev  = exp_int();
      int_m = v;
      bus.i_s_int = v;
      @(negedge clk);
      chk("int_lat1", 32'(bus.o_m_int), 32'(prev));
      @(negedge clk);
      chk("int_lat2", 32'(bus.o_m_int), 32'(exp_int()));
   endtask

   task automatic chk_int();
      repeat (2) @(negedge clk);
      chk("m_int", 32'(bus.o_m_int), 32'(exp_int()));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [7:0] idx;
      int         w;
      logic [31:0] a;
      rst = 1'b1;
      master_idle();
      bus.i_m_sel = '0; bus.i_m_adr = '0; bus.i_m_dat = '0;
      bus.i_s_ack = '0; bus.i_s_dat = '0; bus.i_s_int = '0;
      mask_m = '1; int_m = '0;
      repeat (3) @(negedge clk);
      chk("reset_m_out", {29'h0, bus.o_m_ack, bus.o_m_err, bus.o_m_int}, 32'h0);
      chk("reset_m_dat", bus.o_m_dat, 32'h0);
      chk("reset_s_stb", 32'(bus.o_s_stb | bus.o_s_cyc | bus.o_s_we), 32'h0);
      rst = 1'b0;
      @(negedge clk);

      run_txn(1'b1, 32'h0200_0010, 32'hDEAD_BEEF, 4'hF, 0, 32'h0BAD_F00D, -1, -1);
      run_txn(1'b0, 32'h0100_0000, 32'h0, 4'hF, 3, 32'h1234_5678, -1, -1);
      run_txn(1'b0, 32'h0700_0000, 32'h0, 4'hF, 0, 32'h0, -1, -1);
      run_txn(1'b0, 32'h0000_0000, 32'h0, 4'hF, -1, 32'h0, -1, -1);
      run_txn(1'b0, 32'h0000_0000, 32'h0, 4'hF, T - 1, 32'hCAFE_0016, -1, -1);

      set_int(4'b0101);
      run_txn(1'b0, 32'hFF00_0000, 32'h0, 4'hF, 0, 32'h0, -1, -1);
      run_txn(1'b1, 32'hFF00_0004, 32'h0000_0004, 4'b0001, 0, 32'h0, -1, -1);
      chk_int();
      run_txn(1'b0, 32'hFF00_0004, 32'h0, 4'hF, 0, 32'h0, -1, -1);
      run_txn(1'b1, 32'hFF00_0004, 32'h0, 4'hF, 0, 32'h0, -1, -1);
      chk_int();

      run_txn(1'b0, 32'h0300_0040, 32'h0, 4'h3, -1, 32'h0, 3, -1);
      run_txn(1'b1, 32'h0100_0020, 32'h5555_AAAA, 4'hC, -1, 32'h0, -1, 4);
      run_txn(1'b0, 32'hFF00_0004, 32'h0, 4'hF, 0, 32'h0, -1, -1);
      chk_int();

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) set_int(NS'($urandom));
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: begin
               idx = 8'($urandom_range(0, NS - 1));
               w   = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 4));
            end
            6, 7: begin idx = 8'hFF; w = 0; end
            default: begin idx = 8'($urandom_range(NS, 254)); w = 0; end
         endcase
         a = {idx, 24'($urandom)};
         if (idx == 8'hFF) a[23:0] = 24'(4 * $urandom_range(0, 2));
         run_txn(1'($urandom), a, $urandom, 4'($urandom), w, $urandom, -1, -1);
         chk_int();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
